// File: rtl/writeback_unit_pkg.sv
// Shared types for the register-file writeback path: data words, register
// indices and the buffered writeback request.
package writeback_unit_pkg;

  typedef logic [31:0] uint32_t;
  typedef uint32_t     word;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rd;
    word      data;
  } wb_req_t;

  // One-hot register select; x0 is hardwired so its bit is always clear.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t r);
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Result producers (ALU, LSU) and the single regfile write port of the
// writeback unit, bundled so execute/memory stages and the regfile bind one bus.
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  // valid/ready: a result transfers at the posedge where valid && ready are
  // both high; the producer holds rd/data stable while valid is high and not
  // yet accepted. ready never depends on the producer's own valid, except that
  // alu_ready is withdrawn while lsu_valid is high (LSU has priority).
  logic     alu_valid;
  logic     alu_ready;
  reg_idx_t alu_rd;
  word      alu_data;

  logic     lsu_valid;
  logic     lsu_ready;
  reg_idx_t lsu_rd;
  word      lsu_data;

  reg_idx_t rd_index;
  word      rd_in;
  logic     rd_we;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  rd_index, rd_in, rd_we
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output rd_index, rd_in, rd_we
  );

endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// Small in-order buffer for writeback requests. Pointers carry one extra MSB
// so full and empty are distinguished without a separate counter.
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_req_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  // A push is refused whenever full, even if the head leaves on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-side producer for the integer register file: arbitrates ALU/LSU
// results into a FIFO, drains it onto the regfile write port, tracks pending writes.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  writeback_unit_if.slave               bus,
  input  logic                          hold,
  input  logic                          issue_valid,
  input  reg_idx_t                      issue_rd,
  output logic [NUM_REGS-1:0]           busy_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  wb_req_t              push_req;
  wb_req_t              head;
  logic                 write_now;

  reg_idx_t             idx_q;
  word                  data_q;
  logic                 we_q;
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_set;
  logic [NUM_REGS-1:0]  busy_clr;

  // LSU wins arbitration outright; ALU only sees ready when LSU is idle.
  assign bus.lsu_ready = !full;
  assign bus.alu_ready = !full && !bus.lsu_valid;

  assign push = !full && (bus.lsu_valid || bus.alu_valid);

  always_comb begin
    push_req = '0;
    if (bus.lsu_valid) begin
      push_req.rd   = bus.lsu_rd;
      push_req.data = bus.lsu_data;
    end else begin
      push_req.rd   = bus.alu_rd;
      push_req.data = bus.alu_data;
    end
  end

  assign pop       = !hold && !empty;
  assign write_now = pop && (head.rd != '0);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (wb_req_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Entries for x0 are popped and dropped; the port then idles with index/data
  // left at their last written value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= write_now;
      if (write_now) begin
        idx_q  <= head.rd;
        data_q <= head.data;
      end
    end
  end

  assign bus.rd_index = idx_q;
  assign bus.rd_in    = data_q;
  assign bus.rd_we    = we_q;

  assign busy_set = issue_valid ? reg_onehot(issue_rd) : '0;
  assign busy_clr = write_now   ? reg_onehot(head.rd)  : '0;

  // A new issue on the same edge as the drain of the previous write keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~busy_clr) | busy_set;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios then random traffic, checked
// against a queue-level model of the buffer, write port and pending-register set.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                clk;
  logic                rst;
  logic                hold;
  logic                issue_valid;
  reg_idx_t            issue_rd;
  logic [NUM_REGS-1:0] busy_mask;
  logic [CW-1:0]       fifo_count;

  writeback_unit_if wif ();

  writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (wif),
    .hold        (hold),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy_mask   (busy_mask),
    .fifo_count  (fifo_count)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters / check ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // fifo_m: results accepted but not yet drained; exp_q: regfile writes due.
  logic [36:0]         fifo_m [$];
  logic [36:0]         exp_q  [$];
  logic                exp_we;
  logic [NUM_REGS-1:0] busy_m;
  word                 regs [NUM_REGS];

  initial begin
    exp_we = 1'b0;
    busy_m = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        fifo_m.delete();
        exp_q.delete();
        exp_we = 1'b0;
        busy_m = '0;
      end else begin
        logic        was_full;
        logic        accept;
        logic [36:0] acc_entry;
        logic [36:0] h;
        was_full  = (fifo_m.size() == DEPTH);
        accept    = (wif.lsu_valid || wif.alu_valid) && !was_full;
        acc_entry = wif.lsu_valid ? {wif.lsu_rd, wif.lsu_data} : {wif.alu_rd, wif.alu_data};
        exp_we    = 1'b0;
        if (!hold && fifo_m.size() > 0) begin
          h = fifo_m.pop_front();
          if (h[36:32] != 5'd0) begin
            exp_q.push_back(h);
            exp_we = 1'b1;
            busy_m[h[36:32]] = 1'b0;
          end
        end
        if (issue_valid && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
        if (accept) fifo_m.push_back(acc_entry);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("lsu_ready",  64'(wif.lsu_ready), 64'(fifo_m.size() < DEPTH));
      chk("alu_ready",  64'(wif.alu_ready), 64'((fifo_m.size() < DEPTH) && !wif.lsu_valid));
      chk("fifo_count", 64'(fifo_count),    64'(fifo_m.size()));
      chk("busy_mask",  64'(busy_mask),     64'(busy_m));
      chk("rd_we",      64'(wif.rd_we),     64'(exp_we));
      if (wif.rd_we) begin
        regs[wif.rd_index] = wif.rd_in;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(wif.rd_index), 64'hFFFF);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("rd_index", 64'(wif.rd_index), 64'(e[36:32]));
          chk("rd_in",    64'(wif.rd_in),    64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wif.alu_valid = 1'b0; wif.alu_rd = '0; wif.alu_data = '0;
    wif.lsu_valid = 1'b0; wif.lsu_rd = '0; wif.lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic send_alu(input reg_idx_t rd, input word d);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    wif.alu_valid = 1'b1;
    wif.alu_rd    = rd;
    wif.alu_data  = d;
    while (!done && n < 50) begin
      @(negedge clk);
      if (wif.alu_ready) done = 1'b1;
      else n++;
    end
    chk("alu_accept_wait", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    wif.alu_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    hold = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_rd_we",      64'(wif.rd_we),    64'd0);
    chk("rst_rd_index",   64'(wif.rd_index), 64'd0);
    chk("rst_rd_in",      64'(wif.rd_in),    64'd0);
    chk("rst_busy",       64'(busy_mask),    64'd0);
    chk("rst_count",      64'(fifo_count),   64'd0);
    chk("rst_alu_ready",  64'(wif.alu_ready), 64'd1);
    #2 rst = 1'b0;
    tick();

    // 1: single ALU write
    send_alu(5'd5, 32'hDEADBEEF);
    repeat (3) tick();
    chk("t1_x5", 64'(regs[5]), 64'hDEADBEEF);

    // 2: LSU priority over ALU in the same cycle
    wif.alu_valid = 1'b1; wif.alu_rd = 5'd4; wif.alu_data = 32'h22;
    wif.lsu_valid = 1'b1; wif.lsu_rd = 5'd3; wif.lsu_data = 32'h11;
    @(negedge clk);
    chk("t2_alu_ready", 64'(wif.alu_ready), 64'd0);
    chk("t2_lsu_ready", 64'(wif.lsu_ready), 64'd1);
    tick();
    wif.lsu_valid = 1'b0;
    tick();
    wif.alu_valid = 1'b0;
    repeat (4) tick();
    chk("t2_x3", 64'(regs[3]), 64'h11);
    chk("t2_x4", 64'(regs[4]), 64'h22);

    // 3: hold fills the buffer, release drains in order
    hold = 1'b1;
    send_alu(5'd10, 32'hA0A0_0010);
    send_alu(5'd11, 32'hA0A0_0011);
    fork
      send_alu(5'd12, 32'hA0A0_0012);
      begin
        @(negedge clk);
        chk("t3_count_full", 64'(fifo_count),    64'd2);
        chk("t3_alu_ready",  64'(wif.alu_ready), 64'd0);
        tick();
        tick();
        hold = 1'b0;
      end
    join
    repeat (5) tick();
    chk("t3_x10", 64'(regs[10]), 64'hA0A0_0010);
    chk("t3_x11", 64'(regs[11]), 64'hA0A0_0011);
    chk("t3_x12", 64'(regs[12]), 64'hA0A0_0012);

    // 4: writes to x0 are dropped
    send_alu(5'd0, 32'hFFFFFFFF);
    repeat (3) tick();
    chk("t4_x0",    64'(regs[0]),    64'd0);
    chk("t4_count", 64'(fifo_count), 64'd0);

    // 5: pending scoreboard set/clear, set wins on a coinciding edge
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t5_busy_set", 64'(busy_mask[7]), 64'd1);
    tick();
    wif.alu_valid = 1'b1; wif.alu_rd = 5'd7; wif.alu_data = 32'h0000_0707;
    tick();
    wif.alu_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_busy_clr", 64'(busy_mask[7]), 64'd0);
    tick();
    wif.alu_valid = 1'b1; wif.alu_rd = 5'd7; wif.alu_data = 32'h0000_0777;
    tick();
    wif.alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t5_busy_keep", 64'(busy_mask[7]), 64'd1);
    chk("t5_we",        64'(wif.rd_we),    64'd1);
    repeat (2) tick();

    // 6: async reset mid-cycle drops buffered entries and pending bits
    hold = 1'b1;
    send_alu(5'd9,  32'h0909_0909);
    send_alu(5'd13, 32'h1313_1313);
    issue_valid = 1'b1; issue_rd = 5'd20;
    tick();
    issue_valid = 1'b0;
    hold = 1'b0;
    @(posedge clk);
    #2;
    chk("t6_pre_we",   64'(wif.rd_we),          64'd1);
    chk("t6_pre_busy", 64'(busy_mask != '0),    64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_we",    64'(wif.rd_we),  64'd0);
    chk("t6_rst_busy",  64'(busy_mask),  64'd0);
    chk("t6_rst_count", 64'(fifo_count), 64'd0);
    #4 rst = 1'b0;
    repeat (4) tick();
    chk("t6_x9",  64'(regs[9]),  64'd0);
    chk("t6_x13", 64'(regs[13]), 64'd0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      wif.lsu_valid = ($urandom_range(0, 9) < 3);
      wif.lsu_rd    = reg_idx_t'($urandom_range(0, 31));
      wif.lsu_data  = $urandom;
      wif.alu_valid = ($urandom_range(0, 9) < 5);
      wif.alu_rd    = reg_idx_t'($urandom_range(0, 31));
      wif.alu_data  = $urandom;
      hold          = ($urandom_range(0, 9) < 2);
      issue_valid   = ($urandom_range(0, 9) < 4);
      issue_rd      = reg_idx_t'($urandom_range(0, 31));
      tick();
    end
    idle_inputs();
    hold = 1'b0;
    repeat (8) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
